// File: rtl/stump_mem_responder_pkg.sv
// Shared encodings for the Stump memory responder: FSM states, MMIO offsets
// and the access classifier used by the top-level decode.
package stump_mem_responder_pkg;

    localparam logic [1:0] MR_IDLE = 2'd0;
    localparam logic [1:0] MR_WAIT = 2'd1;
    localparam logic [1:0] MR_RESP = 2'd2;

    localparam logic [15:0] MMIO_OUT  = 16'h0000;
    localparam logic [15:0] MMIO_STAT = 16'h0001;

    localparam int FIFO_ENTRIES = 4;

    typedef enum logic [2:0] {
        ACC_ERR,
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_FIFO_PUSH,
        ACC_STAT_RD
    } acc_kind_e;

    // RAM occupies 0..depth-1; only the two MMIO words are legal above that.
    function automatic acc_kind_e decode_access(input logic rd, input logic wr,
                                                input logic [15:0] addr, input int depth,
                                                input logic [15:0] base);
        if (rd && wr)
            return ACC_ERR;
        if (int'({16'h0000, addr}) < depth)
            return rd ? ACC_RAM_RD : ACC_RAM_WR;
        if (wr && addr == 16'(base + MMIO_OUT))
            return ACC_FIFO_PUSH;
        if (rd && addr == 16'(base + MMIO_STAT))
            return ACC_STAT_RD;
        return ACC_ERR;
    endfunction

endpackage

// File: rtl/stump_mem_responder_if.sv
// Processor-side memory bus plus the output-FIFO drain port.
interface stump_mem_responder_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        mem_ready;
    logic        mem_err;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output mem_ren, mem_wen, address, data_out, out_ready,
        input  data_in, mem_ready, mem_err, out_data, out_valid
    );

    modport slave (
        input  mem_ren, mem_wen, address, data_out, out_ready,
        output data_in, mem_ready, mem_err, out_data, out_valid
    );
endinterface

// File: rtl/stump_out_fifo.sv
// 4x16 synchronous FIFO; head word and valid are registered so the drain port
// sees a pushed word one cycle after the push edge.
module stump_out_fifo
    import stump_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [2:0]  count,
    output logic [15:0] out_data,
    output logic        out_valid
);
    logic [15:0] mem_q [FIFO_ENTRIES];
    logic [15:0] mem_d [FIFO_ENTRIES];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        pop_ok, push_ok;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign pop_ok  = pop && (count_q != 3'd0);
    assign push_ok = push && ((count_q != 3'(FIFO_ENTRIES)) || pop_ok);

    always_comb begin
        mem_d = mem_q;
        if (push_ok)
            mem_d[wr_ptr_q] = push_data;
        wr_ptr_d    = wr_ptr_q + 2'(push_ok);
        rd_ptr_d    = rd_ptr_q + 2'(pop_ok);
        count_d     = count_q + 3'(push_ok) - 3'(pop_ok);
        out_valid_d = (count_d != 3'd0);
        out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign full      = (count_q == 3'(FIFO_ENTRIES));
    assign empty     = (count_q == 3'd0);
    assign count     = count_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
endmodule

// File: rtl/stump_mem_responder.sv
// Stump memory responder: word RAM with programmable wait states, one-cycle
// mem_ready completion, and MMIO access to an output FIFO.
module stump_mem_responder
    import stump_mem_responder_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
    input logic                  clk,
    input logic                  rst,
    stump_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [15:0] data_in_q, data_in_d;
    logic        ready_q, ready_d, err_q, err_d;

    logic [15:0] ram_q [DEPTH];
    logic        req_rd, req_wr, going_resp, stall, fifo_push, ram_we;
    logic [15:0] req_addr;
    logic [AW-1:0] ram_idx;
    acc_kind_e   kind;
    logic        fifo_full, fifo_empty;
    logic [2:0]  fifo_count;

    // In IDLE the live request is decoded so a zero-wait access can respond immediately.
    assign req_rd   = (state_q == MR_IDLE) ? bus.mem_ren : rd_q;
    assign req_wr   = (state_q == MR_IDLE) ? bus.mem_wen : wr_q;
    assign req_addr = (state_q == MR_IDLE) ? bus.address : addr_q;
    assign ram_idx  = req_addr[AW-1:0];
    assign kind     = decode_access(req_rd, req_wr, req_addr, DEPTH, MMIO_BASE);

    assign stall = (kind == ACC_FIFO_PUSH) && (fifo_count == 3'(FIFO_ENTRIES))
                   && !(bus.out_ready && !fifo_empty);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_in_d  = data_in_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        going_resp = 1'b0;
        case (state_q)
            MR_IDLE: begin
                if (bus.mem_ren || bus.mem_wen) begin
                    rd_d    = bus.mem_ren;
                    wr_d    = bus.mem_wen;
                    addr_d  = bus.address;
                    wdata_d = bus.data_out;
                    if (WAIT_STATES == 0 && !stall) begin
                        going_resp = 1'b1;
                    end else begin
                        state_d = MR_WAIT;
                        cnt_d   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
                    end
                end
            end
            MR_WAIT: begin
                if (cnt_q != 4'd0)
                    cnt_d = cnt_q - 4'd1;
                else if (!stall)
                    going_resp = 1'b1;
            end
            MR_RESP: state_d = MR_IDLE;
            default: state_d = MR_IDLE;
        endcase

        if (going_resp) begin
            state_d = MR_RESP;
            ready_d = 1'b1;
            err_d   = (kind == ACC_ERR);
            case (kind)
                ACC_RAM_RD:  data_in_d = ram_q[ram_idx];
                ACC_STAT_RD: data_in_d = {14'b0, fifo_full, fifo_empty};
                default:     data_in_d = 16'h0000;
            endcase
        end
    end

    assign fifo_push = going_resp && (kind == ACC_FIFO_PUSH);
    assign ram_we    = (state_q == MR_RESP) && (kind == ACC_RAM_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MR_IDLE;
            cnt_q     <= 4'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            data_in_q <= 16'h0000;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            data_in_q <= data_in_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (ram_we && !rst)
            ram_q[ram_idx] <= wdata_q;
    end

    stump_out_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wdata_d),
        .pop       (bus.out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid)
    );

    assign bus.data_in   = data_in_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
endmodule

// File: tb/tb_stump_mem_responder.sv
// Directed bench for stump_mem_responder: a one-wait-state instance for the
// vector table and FIFO sequences, a zero-wait-state instance for latency.
module tb_stump_mem_responder;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    stump_mem_responder_if bus1 ();
    stump_mem_responder_if bus0 ();

    stump_mem_responder #(.DEPTH(1024), .WAIT_STATES(1), .MMIO_BASE(16'hFF00)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    stump_mem_responder #(.DEPTH(1024), .WAIT_STATES(0), .MMIO_BASE(16'hFF00)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
        bit          chk_data;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit sel0, input logic ren, input logic wen,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (sel0) begin
            bus0.mem_ren = ren; bus0.mem_wen = wen; bus0.address = addr; bus0.data_out = wdata;
        end else begin
            bus1.mem_ren = ren; bus1.mem_wen = wen; bus1.address = addr; bus1.data_out = wdata;
        end
    endtask

    // Called just after a rising edge with the FSM idle; returns edges-to-ready (-1 on timeout).
    task automatic access(input bit sel0, input logic ren, input logic wen,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat, output logic [15:0] rdata, output logic err);
        int   i;
        logic rdy;
        lat   = -1;
        rdata = 16'hxxxx;
        err   = 1'bx;
        i     = 0;
        set_req(sel0, ren, wen, addr, wdata);
        while (lat < 0 && i < 40) begin
            @(posedge clk);
            i++;
            @(negedge clk);
            rdy = sel0 ? bus0.mem_ready : bus1.mem_ready;
            if (rdy) begin
                lat   = i;
                rdata = sel0 ? bus0.data_in : bus1.data_in;
                err   = sel0 ? bus0.mem_err : bus1.mem_err;
            end
        end
        @(posedge clk);
        #1;
        set_req(sel0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;
        bit          seen;

        vecs[0]  = '{1'b0, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 16'h0007, 16'h7777, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0007, 16'h0000, 16'h7777, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 16'h0005, 16'hDEAD, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 16'hFF01, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'hFF01, 16'h0000, 16'h0001, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 16'h03FF, 16'hABCD, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hABCD, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 16'h0400, 16'h1111, 16'h0000, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 16'hFF02, 16'h0000, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        bus1.out_ready = 1'b0;
        bus0.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data_in", 32'(bus1.data_in), 32'h0);
        check("reset mem_ready", 32'(bus1.mem_ready), 32'h0);
        check("reset mem_err", 32'(bus1.mem_err), 32'h0);
        check("reset out_valid", 32'(bus1.out_valid), 32'h0);
        check("reset out_data", 32'(bus1.out_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 15; v++) begin
            access(1'b0, vecs[v].ren, vecs[v].wen, vecs[v].addr, vecs[v].wdata, lat, rd, er);
            check($sformatf("vec%0d latency", v), 32'(lat), 32'd2);
            check($sformatf("vec%0d mem_err", v), 32'(er), 32'(vecs[v].exp_err));
            if (vecs[v].chk_data)
                check($sformatf("vec%0d data_in", v), 32'(rd), 32'(vecs[v].exp_data));
        end

        // Zero wait states: response on the cycle right after the request.
        access(1'b1, 1'b0, 1'b1, 16'h0000, 16'hBEEF, lat, rd, er);
        check("ws0 write latency", 32'(lat), 32'd1);
        access(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, lat, rd, er);
        check("ws0 read latency", 32'(lat), 32'd1);
        check("ws0 read data", 32'(rd), 32'hBEEF);
        check("ws0 read err", 32'(er), 32'h0);

        // Fill the FIFO with the consumer stalled, then stall a fifth push.
        for (int k = 1; k <= 4; k++) begin
            access(1'b0, 1'b0, 1'b1, 16'hFF00, 16'hA000 + 16'(k), lat, rd, er);
            check($sformatf("fill%0d latency", k), 32'(lat), 32'd2);
            check($sformatf("fill%0d err", k), 32'(er), 32'h0);
        end
        check("full head", 32'(bus1.out_data), 32'hA001);
        access(1'b0, 1'b1, 1'b0, 16'hFF01, 16'h0000, lat, rd, er);
        check("status full", 32'(rd), 32'h0002);
        set_req(1'b0, 1'b0, 1'b1, 16'hFF00, 16'hA005);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.mem_ready) seen = 1'b1;
        end
        check("stalled push no ready", 32'(seen), 32'h0);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        check("pop head A001", 32'(bus1.out_data), 32'hA001);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        check("fifth ready after pop", 32'(bus1.mem_ready), 32'h1);
        check("fifth err", 32'(bus1.mem_err), 32'h0);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("drain%0d valid", k), 32'(bus1.out_valid), 32'h1);
            check($sformatf("drain%0d data", k), 32'(bus1.out_data), 32'(16'hA000 + 16'(k)));
            bus1.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus1.out_ready = 1'b0;
        end
        check("drained empty", 32'(bus1.out_valid), 32'h0);

        // Simultaneous push and pop with two entries queued.
        access(1'b0, 1'b0, 1'b1, 16'hFF00, 16'hB001, lat, rd, er);
        access(1'b0, 1'b0, 1'b1, 16'hFF00, 16'hB002, lat, rd, er);
        set_req(1'b0, 1'b0, 1'b1, 16'hFF00, 16'hB003);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        check("pp head before", 32'(bus1.out_data), 32'hB001);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        check("pp ready", 32'(bus1.mem_ready), 32'h1);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'hFF01, 16'h0000, lat, rd, er);
        check("pp status", 32'(rd), 32'h0000);
        for (int k = 2; k <= 3; k++) begin
            check($sformatf("pp%0d valid", k), 32'(bus1.out_valid), 32'h1);
            check($sformatf("pp%0d data", k), 32'(bus1.out_data), 32'(16'hB000 + 16'(k)));
            bus1.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus1.out_ready = 1'b0;
        end
        check("pp count 2 drained", 32'(bus1.out_valid), 32'h0);

        // Reset during the wait state of a RAM write, with a word parked in the FIFO.
        access(1'b0, 1'b0, 1'b1, 16'hFF00, 16'hC001, lat, rd, er);
        check("parked valid", 32'(bus1.out_valid), 32'h1);
        set_req(1'b0, 1'b0, 1'b1, 16'h0007, 16'h5555);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        seen = 1'b0;
        @(negedge clk);
        if (bus1.mem_ready) seen = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus1.mem_ready) seen = 1'b1;
            @(posedge clk);
        end
        #1;
        check("abort no ready", 32'(seen), 32'h0);
        check("abort fifo flushed", 32'(bus1.out_valid), 32'h0);
        access(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, lat, rd, er);
        check("abort ram kept", 32'(rd), 32'h7777);
        check("abort read latency", 32'(lat), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stump_mem_responder.md
# stump_mem_responder

Memory-side responder for the Stump processor bus: the far end of the `mem_ren`/`mem_wen` requests issued by the control decoder in the FETCH and MEMORY states. Serves word reads and writes from an internal RAM after a programmable number of wait states, and signals completion with a one-cycle `mem_ready` pulse. Two memory-mapped locations feed a small output FIFO with a valid/ready drain port.

## Interface
- `DEPTH`, 1024: RAM words; valid RAM addresses are 0..DEPTH-1.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response (0..15).
- `MMIO_BASE`, 16'hFF00: `MMIO_BASE` is the output-data register (write). `MMIO_BASE+1` is the status register (read).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_ren`  in  1  read request; held stable until `mem_ready`.
- `mem_wen`  in  1  write request; held stable until `mem_ready`.
- `address`  in  16  word address.
- `data_out`  in  16  write data from the processor.
- `data_in`  out  16  read data; valid in the `mem_ready` cycle.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  qualifies `mem_ready`; the access was illegal.
- `out_data`  out  16  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head when `out_valid && out_ready`.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: a request (`mem_ren | mem_wen`) latches `address`, `data_out` and the request kind. The FSM then goes to WAIT, or straight to RESP if `WAIT_STATES == 0`.
  - WAIT: down-counter loaded with `WAIT_STATES-1`. Go to RESP when it reaches 0 and no stall condition holds.
  - RESP: assert `mem_ready` for exactly one cycle, then return to IDLE.
- Access decode, from the latched request:
  - `mem_ren` and `mem_wen` both high: error, no side effect.
  - RAM read: `data_in` = RAM[addr], registered on the WAIT→RESP edge.
  - RAM write: RAM[addr] written on the RESP cycle edge.
  - Write to `MMIO_BASE`: push the data into the FIFO.
  - Read from `MMIO_BASE+1`: `data_in` = {14'b0, full, empty}.
  - Read from `MMIO_BASE`, write to `MMIO_BASE+1`, or any other address ≥ DEPTH: error.
- Error response: `mem_err=1` with `mem_ready`, `data_in=0`, no RAM or FIFO change.
- FIFO stall: a FIFO push while the FIFO is full holds the FSM in WAIT until a pop occurs. The push happens on the WAIT→RESP edge.
- FIFO: 4 entries. A simultaneous push and pop with count 1..3 leaves count unchanged. A pop when empty is ignored.
- Requests arriving while not in IDLE are ignored. The requester must deassert in the cycle after `mem_ready`, or a new access is accepted.

## Timing
- Reset values: `data_in=0`, `mem_ready=0`, `mem_err=0`, `out_valid=0`, `out_data=0`, FSM=IDLE, FIFO empty, counter 0. RAM contents are not reset.
- Latency: request sampled in IDLE at cycle T gives `mem_ready` at cycle T+1+WAIT_STATES, in the absence of a FIFO stall.
- Back-to-back: the minimum request-to-request interval is WAIT_STATES+2 cycles.
- `out_data` and `out_valid` are registered. A pushed word appears at the head one cycle after the push edge.
- Reset mid-transaction aborts it:
  - no `mem_ready`;
  - a pending RAM write or FIFO push is not performed;
  - FIFO contents are discarded.

## Structure
- `Stump_definitions.v` gains:
  - FSM state encodings `MR_IDLE`, `MR_WAIT`, `MR_RESP`;
  - default `MMIO` offsets `MMIO_OUT` and `MMIO_STAT`.
- One sub-module, `stump_out_fifo`: 4×16 synchronous FIFO with push, pop, full, empty and count outputs. RAM is inferred inside the top module.

## Test plan
- Reset, then WAIT_STATES=1: write 16'h1234 to address 5, then read address 5. Required: `mem_ready` 2 cycles after each request; `data_in=16'h1234`, `mem_err=0`.
- WAIT_STATES=0: read address 0 with the RAM preloaded to 16'hBEEF. Required: `mem_ready` and `data_in=16'hBEEF` at T+1.
- Read address 16'h0800 (DEPTH=1024). Required: `mem_ready=1`, `mem_err=1`, `data_in=0`. Also assert `mem_ren` and `mem_wen` together: same error response, and RAM is unchanged.
- Hold `out_ready=0` and write 16'hA001..16'hA005 to FF00. Required:
  - the first four complete normally;
  - the fifth stalls with no `mem_ready`;
  - a status read would show full=1.
  Then pulse `out_ready` for one cycle. Required: fifth `mem_ready` follows, and the drain order is A001..A005.
- Assert `rst` during the WAIT of a write of 16'h5555 to address 7. Required: no `mem_ready`, and a subsequent read of address 7 returns its prior value.
- With `out_valid=1` and count=2, push and pop in the same cycle. Required: count stays 2 and head order is preserved.
